// File: rtl/gshare_branch_predictor.sv
// rtl/gshare_branch_predictor.sv - gshare global-history branch predictor, optional BP_STATS_EN statistics counters
module gshare_branch_predictor #(
    parameter int PC_W       = 32,
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = 4,
    parameter int CTR_BITS   = 2
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  LookupValid_ID,
    input  logic [PC_W-1:0]       PC_ID,
    output logic                  Prediction,
    output logic                  PredValid,
    output logic [INDEX_BITS-1:0] PredIndex,
    input  logic                  UpdateValid_EX,
    input  logic [INDEX_BITS-1:0] UpdateIndex_EX,
    input  logic                  BranchDecision_EX
`ifdef BP_STATS_EN
    ,
    input  logic                  PredictedTaken_EX,
    output logic [31:0]           LookupCount,
    output logic [31:0]           MispredictCount
`endif
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    // Weakly-not-taken: all ones shifted right once (01 for 2 bits, 0 for 1 bit).
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

    // Illegal configurations are rejected at elaboration.
    if (HIST_BITS < 1 || HIST_BITS > INDEX_BITS) begin : g_bad_hist
        $error("HIST_BITS must be in 1..INDEX_BITS");
    end
    if (CTR_BITS < 1 || CTR_BITS > 4) begin : g_bad_ctr
        $error("CTR_BITS must be in 1..4");
    end
    if (PC_W < INDEX_BITS + 3) begin : g_bad_pc
        $error("PC_W too narrow for INDEX_BITS");
    end

    logic [HIST_BITS-1:0]  ghr;
    logic [HIST_BITS-1:0]  ghr_next;
    logic [CTR_BITS-1:0]   pht [DEPTH];
    logic [INDEX_BITS-1:0] idx;
    logic [CTR_BITS-1:0]   ctr_cur;
    logic [CTR_BITS-1:0]   ctr_next;
    logic                  unused_pc;

    // Only the word-aligned index field of the PC participates in hashing.
    assign unused_pc = ^{PC_ID[PC_W-1:INDEX_BITS+2], PC_ID[1:0]};
    assign idx       = PC_ID[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
    assign ctr_cur   = pht[UpdateIndex_EX];

    if (HIST_BITS == 1) begin : g_hist1
        assign ghr_next = BranchDecision_EX;
    end else begin : g_histn
        assign ghr_next = {ghr[HIST_BITS-2:0], BranchDecision_EX};
    end

    // Saturating counter step toward the resolved direction, no wrap-around.
    always_comb begin
        ctr_next = ctr_cur;
        if (BranchDecision_EX) begin
            if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + 1'b1;
        end else begin
            if (ctr_cur != '0) ctr_next = ctr_cur - 1'b1;
        end
    end

    // Pattern table: reads below see pre-edge contents, so same-index lookups get the old counter.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) pht[i] <= CTR_INIT;
        end else if (UpdateValid_EX) begin
            pht[UpdateIndex_EX] <= ctr_next;
        end
    end

    // Global history only advances on resolved branches.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ghr <= '0;
        end else if (UpdateValid_EX) begin
            ghr <= ghr_next;
        end
    end

    // Registered lookup result; index and prediction hold when no lookup is issued.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Prediction <= 1'b0;
            PredValid  <= 1'b0;
            PredIndex  <= '0;
        end else begin
            PredValid <= LookupValid_ID;
            if (LookupValid_ID) begin
                PredIndex  <= idx;
                Prediction <= pht[idx][CTR_BITS-1];
            end
        end
    end

`ifdef BP_STATS_EN
    // Free-running lookup and misprediction counters, wrapping modulo 2^32.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            LookupCount     <= '0;
            MispredictCount <= '0;
        end else begin
            if (LookupValid_ID) LookupCount <= LookupCount + 32'd1;
            if (UpdateValid_EX && (PredictedTaken_EX != BranchDecision_EX))
                MispredictCount <= MispredictCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb/tb_gshare_branch_predictor.sv - scoreboard testbench for gshare_branch_predictor
module tb_gshare_branch_predictor;

    logic        Clock;
    logic        Reset_n;
    logic        LookupValid_ID;
    logic [31:0] PC_ID;
    logic        Prediction;
    logic        PredValid;
    logic [5:0]  PredIndex;
    logic        UpdateValid_EX;
    logic [5:0]  UpdateIndex_EX;
    logic        BranchDecision_EX;
    logic        ptk;
`ifdef BP_STATS_EN
    logic [31:0] LookupCount;
    logic [31:0] MispredictCount;
`endif

    int checks = 0;
    int errors = 0;
    int pushes = 0;
    int pops   = 0;
    logic [6:0] exp_q [$];

    gshare_branch_predictor #(
        .PC_W(32), .INDEX_BITS(6), .HIST_BITS(4), .CTR_BITS(2)
    ) dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .LookupValid_ID(LookupValid_ID),
        .PC_ID(PC_ID),
        .Prediction(Prediction),
        .PredValid(PredValid),
        .PredIndex(PredIndex),
        .UpdateValid_EX(UpdateValid_EX),
        .UpdateIndex_EX(UpdateIndex_EX),
        .BranchDecision_EX(BranchDecision_EX)
`ifdef BP_STATS_EN
        ,
        .PredictedTaken_EX(ptk),
        .LookupCount(LookupCount),
        .MispredictCount(MispredictCount)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented prediction is matched against the next scoreboard entry.
    always @(negedge Clock) begin
        if (Reset_n && PredValid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_predvalid", 32'd1, 32'd0);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                pops++;
                check("pred_index", 32'(PredIndex), 32'(e[6:1]));
                check("prediction", 32'(Prediction), 32'(e[0]));
            end
        end
    end

    task automatic cycle(input logic lv, input logic [31:0] pc, input logic uv,
                         input logic [5:0] uidx, input logic dec, input logic pt);
        LookupValid_ID    = lv;
        PC_ID             = pc;
        UpdateValid_EX    = uv;
        UpdateIndex_EX    = uidx;
        BranchDecision_EX = dec;
        ptk               = pt;
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_pred(input logic [5:0] eidx, input logic epred);
        exp_q.push_back({eidx, epred});
        pushes++;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [5:0] eidx, input logic epred);
        expect_pred(eidx, epred);
        cycle(1'b1, pc, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [5:0] uidx, input logic dec);
        cycle(1'b0, 32'd0, 1'b1, uidx, dec, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 32'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic reset_pulse();
        @(negedge Clock);
        #1;
        Reset_n = 1'b0;
        #1;
        check("rst_pulse_predvalid", 32'(PredValid), 32'd0);
        @(posedge Clock);
        @(negedge Clock);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n = 1'b0;
        LookupValid_ID = 1'b0; PC_ID = '0; UpdateValid_EX = 1'b0;
        UpdateIndex_EX = '0; BranchDecision_EX = 1'b0; ptk = 1'b0;
        #8;
        check("reset_prediction", 32'(Prediction), 32'd0);
        check("reset_predvalid", 32'(PredValid), 32'd0);
        check("reset_predindex", 32'(PredIndex), 32'd0);
        #4;
        Reset_n = 1'b1;

        // 1: first lookup, then hold behaviour
        lookup(32'h40, 6'h10, 1'b0);
        idle();
        check("idle_predvalid", 32'(PredValid), 32'd0);
        check("idle_predindex_hold", 32'(PredIndex), 32'h10);

        // 2: train entry 0x10 twice; GHR becomes 0011
        update(6'h10, 1'b1);
        update(6'h10, 1'b1);
        lookup(32'h40, 6'h13, 1'b0);
        lookup(32'h4C, 6'h10, 1'b1);

        // 3: saturation on index 5
        for (int i = 0; i < 5; i++) update(6'd5, 1'b1);
        lookup(32'h28, 6'd5, 1'b1);
        for (int i = 0; i < 5; i++) update(6'd5, 1'b0);
        lookup(32'h14, 6'd5, 1'b0);
        update(6'd5, 1'b1);
        lookup(32'h10, 6'd5, 1'b0);
        update(6'd5, 1'b1);
        lookup(32'h18, 6'd5, 1'b1);

        // 4: same-cycle lookup and update on 0x20 (GHR 0011 -> 0111)
        expect_pred(6'h20, 1'b0);
        cycle(1'b1, 32'h8C, 1'b1, 6'h20, 1'b1, 1'b0);
        lookup(32'h9C, 6'h20, 1'b1);

        // 5: asynchronous reset mid-stream with a lookup and update in flight
        lookup(32'h9C, 6'h20, 1'b1);
        LookupValid_ID = 1'b1; PC_ID = 32'h40; UpdateValid_EX = 1'b1;
        UpdateIndex_EX = 6'h10; BranchDecision_EX = 1'b1;
        @(negedge Clock);
        #1;
        Reset_n = 1'b0;
        #1;
        check("async_rst_prediction", 32'(Prediction), 32'd0);
        check("async_rst_predvalid", 32'(PredValid), 32'd0);
        check("async_rst_predindex", 32'(PredIndex), 32'd0);
        @(posedge Clock);
        #1;
        LookupValid_ID = 1'b0; UpdateValid_EX = 1'b0;
        @(negedge Clock);
        #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 64; i++) lookup(32'(i) << 2, 6'(i), 1'b0);
        idle();

`ifdef BP_STATS_EN
        // 6: statistics counters
        reset_pulse();
        check("stats_lookup_after_rst", LookupCount, 32'd0);
        check("stats_misp_after_rst", MispredictCount, 32'd0);
        for (int i = 0; i < 10; i++) lookup(32'(i) << 2, 6'(i), 1'b0);
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 32'd0, 1'b1, 6'h3F, 1'b0, (i == 2 || i == 5 || i == 7));
        idle();
        check("stats_lookup_count", LookupCount, 32'd10);
        check("stats_misp_count", MispredictCount, 32'd3);
        reset_pulse();
        check("stats_lookup_cleared", LookupCount, 32'd0);
        check("stats_misp_cleared", MispredictCount, 32'd0);
`endif

        idle();
        idle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("pops_vs_pushes", 32'(pops), 32'(pushes));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
Parametrised, clocked global-history branch predictor for the ID/EX pipeline. Index formation is gshare: PC index bits XOR global history.
- ID issues a lookup by PC and gets a registered taken/not-taken prediction one cycle later, plus the table index used.
- EX carries that index down the pipe and returns it with the resolved outcome to train the saturating counter and shift the history.

Parameters:
PC_W, 32, width of PC_ID
INDEX_BITS, 6, log2 of pattern-table depth (table has 2^INDEX_BITS counters)
HIST_BITS, 4, global history length; legal range 1..INDEX_BITS
CTR_BITS, 2, saturating counter width; legal range 1..4

Ports:
Clock  in  1  rising-edge clock
Reset_n  in  1  asynchronous, active-low reset
LookupValid_ID  in  1  branch present in ID; request prediction this cycle
PC_ID  in  PC_W  PC of branch in ID
Prediction  out  1  predicted direction (1 = taken)
PredValid  out  1  one-cycle pulse: Prediction/PredIndex refer to the previous cycle's lookup
PredIndex  out  INDEX_BITS  table index used for the lookup; pipeline carries it to EX
UpdateValid_EX  in  1  resolved branch in EX this cycle
UpdateIndex_EX  in  INDEX_BITS  index returned from PredIndex for this branch
BranchDecision_EX  in  1  actual outcome (1 = taken)

Behaviour:
- Interface (fixed): one clock, Clock; reset Reset_n is asynchronous and active-low.
- State:
  - GHR: HIST_BITS history register.
  - PHT: 2^INDEX_BITS counters of CTR_BITS each.
  - Output registers: Prediction, PredValid, PredIndex.
- Reset (async, while Reset_n = 0):
  - GHR = 0.
  - Every PHT entry = weakly-not-taken, i.e. 2^(CTR_BITS-1) - 1 (2'b01 at default; 0 when CTR_BITS = 1).
  - Prediction = 0, PredValid = 0, PredIndex = 0.
  - Reset asserted mid-operation discards any in-flight lookup and update.
- Index computation: idx = PC_ID[INDEX_BITS+1:2] XOR {zeros, GHR}. GHR is zero-extended to INDEX_BITS. PC bits [1:0] are ignored.
- Lookup (latency 1):
  - At an edge with LookupValid_ID = 1: PredIndex <= idx, Prediction <= PHT[idx][CTR_BITS-1], PredValid <= 1.
  - At an edge with LookupValid_ID = 0: PredValid <= 0; Prediction and PredIndex hold their values.
- Update:
  - At an edge with UpdateValid_EX = 1, PHT[UpdateIndex_EX] saturating-increments if BranchDecision_EX = 1, else saturating-decrements.
  - Saturation bounds are max 2^CTR_BITS - 1 and min 0; no wrap-around.
  - GHR <= {GHR[HIST_BITS-2:0], BranchDecision_EX} (HIST_BITS = 1: GHR <= BranchDecision_EX).
  - GHR is non-speculative: only resolved branches shift it.
- Simultaneous lookup and update in the same cycle:
  - The lookup uses the pre-edge GHR and the pre-edge PHT contents (read-before-write), including when idx == UpdateIndex_EX.
  - Both state changes commit at the same edge.
- No stalls or backpressure: a lookup every cycle is legal; an update every cycle is legal.
- Out-of-range parameters are a configuration error. Verification checks them with an elaboration-time assertion; no runtime behaviour is defined for them.

Optional Feature:
BP_STATS_EN
- Defined: adds three ports.
  - PredictedTaken_EX, in, 1: the prediction originally given for the branch now in EX.
  - LookupCount, out, 32: increments on every lookup edge.
  - MispredictCount, out, 32: increments on update edges where PredictedTaken_EX != BranchDecision_EX.
  - Both counters reset to 0 asynchronously and wrap modulo 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then lookup PC_ID = 0x40 -> next cycle PredValid = 1, PredIndex = 0x10, Prediction = 0; following cycle with no lookup -> PredValid = 0, PredIndex stays 0x10.
2. Two updates (index 0x10, taken) -> PHT[0x10] goes 1 -> 2 -> 3, GHR = 0b0011.
   - Lookup PC 0x40 -> PredIndex 0x13, Prediction 0.
   - Lookup PC 0x4C -> PredIndex 0x10, Prediction 1.
3. Saturation on index 5: five taken updates -> counter stays 3; then five not-taken updates -> counter 0 and stays 0; lookups mapping to index 5 -> Prediction 0.
4. Same-cycle lookup and update on one index:
   - PHT[idx] = 1, update taken with lookup hitting idx -> Prediction 0 (old value); GHR shift is not visible to this lookup.
   - Next lookup of that entry sees counter 2 -> Prediction 1.
5. Drop Reset_n between clock edges mid-stream -> Prediction, PredValid, PredIndex and GHR go to 0 immediately; after release, all 64 entries predict 0.
6. With BP_STATS_EN: 10 lookups and 10 updates, 3 of them with PredictedTaken_EX != BranchDecision_EX -> LookupCount = 10, MispredictCount = 3; reset clears both to 0.
